// File: rtl/pass_sequencer.sv
// Sequences one fetch / forward / (backward) pass through the network core per
// TR or VL request, owns the sample-memory index counters and reports completion.
module pass_sequencer #(
  parameter int BITS = 16,
  parameter int ADDR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            TR,
  input  logic            VL,
  input  logic            END,
  input  logic [BITS-1:0] TRAIN,
  input  logic [BITS-1:0] VALID,
  input  logic [ADDR-1:0] VAL_BASE,
  output logic [ADDR-1:0] MEM_ADDR,
  output logic            MEM_RD,
  output logic            FWD_START,
  input  logic            FWD_DONE,
  output logic            BWD_START,
  input  logic            BWD_DONE,
  input  logic [BITS-1:0] Error_in,
  output logic            S_Train,
  output logic            S_Error,
  output logic [BITS-1:0] Error,
  output logic            BUSY,
  output logic            OVR
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_FWD, S_BWD, S_REPORT} state_t;

  state_t          state, state_nxt;
  logic            mode_v, mode_v_nxt;
  logic [BITS-1:0] t_idx, v_idx, t_idx_nxt, v_idx_nxt;
  logic [BITS:0]   t_inc, v_inc;
  logic            fwd_hit, bwd_hit;

  logic [ADDR-1:0] mem_addr_nxt;
  logic            mem_rd_nxt, fwd_start_nxt, bwd_start_nxt;
  logic            s_train_nxt, s_error_nxt, busy_nxt, ovr_nxt;
  logic [BITS-1:0] error_nxt;

  // DONE in the same cycle as its START pulse is ignored; the START register
  // marks that first cycle.
  assign fwd_hit = (state == S_FWD) && !FWD_START && FWD_DONE;
  assign bwd_hit = (state == S_BWD) && !BWD_START && BWD_DONE;
  assign t_inc   = {1'b0, t_idx} + 1'b1;
  assign v_inc   = {1'b0, v_idx} + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mode_v    <= 1'b0;
      t_idx     <= '0;
      v_idx     <= '0;
      MEM_ADDR  <= '0;
      MEM_RD    <= 1'b0;
      FWD_START <= 1'b0;
      BWD_START <= 1'b0;
      S_Train   <= 1'b0;
      S_Error   <= 1'b0;
      Error     <= '0;
      BUSY      <= 1'b0;
      OVR       <= 1'b0;
    end else begin
      state     <= state_nxt;
      mode_v    <= mode_v_nxt;
      t_idx     <= t_idx_nxt;
      v_idx     <= v_idx_nxt;
      MEM_ADDR  <= mem_addr_nxt;
      MEM_RD    <= mem_rd_nxt;
      FWD_START <= fwd_start_nxt;
      BWD_START <= bwd_start_nxt;
      S_Train   <= s_train_nxt;
      S_Error   <= s_error_nxt;
      Error     <= error_nxt;
      BUSY      <= busy_nxt;
      OVR       <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mode_v_nxt = mode_v;
    t_idx_nxt  = t_idx;
    v_idx_nxt  = v_idx;
    if (END) begin
      state_nxt = S_IDLE;
      t_idx_nxt = '0;
      v_idx_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (TR) begin
            state_nxt  = S_FETCH;
            mode_v_nxt = 1'b0;
          end else if (VL) begin
            state_nxt  = S_FETCH;
            mode_v_nxt = 1'b1;
          end
        end
        S_FETCH: state_nxt = S_LOAD;
        S_LOAD:  state_nxt = S_FWD;
        S_FWD:   if (fwd_hit) state_nxt = mode_v ? S_REPORT : S_BWD;
        S_BWD:   if (bwd_hit) state_nxt = S_REPORT;
        S_REPORT: begin
          state_nxt = S_IDLE;
          // A zero count makes the compare always true, pinning the index at 0.
          if (mode_v) v_idx_nxt = (v_inc >= {1'b0, VALID}) ? '0 : v_inc[BITS-1:0];
          else        t_idx_nxt = (t_inc >= {1'b0, TRAIN}) ? '0 : t_inc[BITS-1:0];
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    mem_addr_nxt = MEM_ADDR;
    if (state_nxt == S_FETCH)
      mem_addr_nxt = mode_v_nxt ? VAL_BASE + v_idx[ADDR-1:0] : t_idx[ADDR-1:0];
    mem_rd_nxt    = (state_nxt == S_FETCH);
    fwd_start_nxt = (state_nxt == S_FWD) && (state != S_FWD);
    bwd_start_nxt = (state_nxt == S_BWD) && (state != S_BWD);
    s_train_nxt   = (state_nxt == S_REPORT) && !mode_v_nxt;
    s_error_nxt   = (state_nxt == S_REPORT) && mode_v_nxt;
    busy_nxt      = (state_nxt != S_IDLE);
    error_nxt     = Error;
    if (!END && fwd_hit && mode_v) error_nxt = Error_in;
    ovr_nxt = OVR | (!END && (TR || VL) && ((state != S_IDLE) || (TR && VL)));
  end

endmodule
